// File: rtl/tmnt_gfx_pkg.sv
// Shared graphics types for the TMNT tile plane path.
// Pixel/attribute bundle, planar ROM bit order, shifter states.
package tmnt_gfx_pkg;

    localparam int PIX_W   = 4;
    localparam int COL_W   = 8;
    localparam int ROW_PIX = 8;
    localparam int DLY_LEN = 8;

    // LSB position of each bitplane byte inside a 32-bit ROM row
    localparam logic [4:0] PLANE3_LSB = 5'd24;
    localparam logic [4:0] PLANE2_LSB = 5'd16;
    localparam logic [4:0] PLANE1_LSB = 5'd8;
    localparam logic [4:0] PLANE0_LSB = 5'd0;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic [COL_W-1:0] col;
    } pix_attr_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

    // Pixel n (0 = leftmost) sits at bit 7-n of each plane byte
    function automatic logic [PIX_W-1:0] planar_pixel(
        input logic [31:0] row,
        input logic [2:0]  n
    );
        logic [4:0] off;
        off = {2'b00, ~n};
        planar_pixel = {
            row[PLANE3_LSB + off],
            row[PLANE2_LSB + off],
            row[PLANE1_LSB + off],
            row[PLANE0_LSB + off]
        };
    endfunction

endpackage

// File: rtl/k051962_fine_delay.sv
// Fine-scroll delay line: 8 pixel/attribute entries, tap picked by FINE.
// FINE is latched on each pixel enable so a change lands with the next pixel.
module k051962_fine_delay
    import tmnt_gfx_pkg::*;
(
    input  logic       clk_24M,
    input  logic       nRES,
    input  logic       PIX_CE,
    input  logic [2:0] FINE,
    input  pix_attr_t  din,
    output pix_attr_t  dout
);

    pix_attr_t  taps_q [DLY_LEN];
    logic [2:0] fine_q;

    // Shift one entry per pixel; entry i holds the pixel from i pixels ago
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < DLY_LEN; i++) begin
                taps_q[i] <= '0;
            end
            fine_q <= 3'd0;
        end else if (PIX_CE) begin
            taps_q[0] <= din;
            for (int i = 1; i < DLY_LEN; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
            fine_q <= FINE;
        end
    end

    assign dout = taps_q[fine_q];

endmodule

// File: rtl/k051962_plane_shifter.sv
// K051962 tile plane pixel shifter with fine horizontal scroll.
// Define K051962_PLANE_SHIFTER_FLIPX_EN to build horizontal flip support.
module k051962_plane_shifter
    import tmnt_gfx_pkg::*;
(
    input  logic        clk_24M,
    input  logic        nRES,
    input  logic        PIX_CE,
    input  logic        LOAD,
    input  logic [31:0] ROM_D,
    input  logic [7:0]  COL,
    input  logic        FLIP_X,
    input  logic [2:0]  FINE,
    output logic [3:0]  PIX,
    output logic [7:0]  PCOL,
    output logic        OPAQUE
);

    shift_state_t     state_q;
    shift_state_t     state_d;
    logic [2:0]       count_q;
    logic [PIX_W-1:0] shreg_q  [ROW_PIX];
    logic [PIX_W-1:0] load_row [ROW_PIX];
    logic [COL_W-1:0] attr_q;
    logic             load_ok;
    logic             row_done;
    logic             advance;
    pix_attr_t        stream;
    pix_attr_t        tap;

    assign load_ok  = PIX_CE & LOAD;
    assign advance  = PIX_CE & ~LOAD & (state_q == ST_SHIFT);
    assign row_done = advance & (count_q == 3'd7);

`ifdef K051962_PLANE_SHIFTER_FLIPX_EN
    // Unpack the planar row, mirrored when the tile is flipped
    always_comb begin
        for (int n = 0; n < ROW_PIX; n++) begin
            load_row[n] = planar_pixel(
                ROM_D,
                FLIP_X ? 3'(ROW_PIX - 1 - n) : 3'(n)
            );
        end
    end
`else
    logic unused_flip_x;
    assign unused_flip_x = FLIP_X;

    // Unpack the planar row in screen order
    always_comb begin
        for (int n = 0; n < ROW_PIX; n++) begin
            load_row[n] = planar_pixel(ROM_D, 3'(n));
        end
    end
`endif

    // State register
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load always wins over running out of pixels
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            load_ok:  state_d = ST_SHIFT;
            row_done: state_d = ST_EMPTY;
            default:  state_d = state_q;
        endcase
    end

    // Pixel fed to the delay line: head of shifter, or transparent
    always_comb begin
        stream = '0;
        if (state_q == ST_SHIFT) begin
            stream.pix = shreg_q[0];
            stream.col = attr_q;
        end
    end

    // Row shifter, pixel counter and attribute latch
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            for (int n = 0; n < ROW_PIX; n++) begin
                shreg_q[n] <= '0;
            end
            count_q <= 3'd0;
            attr_q  <= '0;
        end else if (load_ok) begin
            for (int n = 0; n < ROW_PIX; n++) begin
                shreg_q[n] <= load_row[n];
            end
            count_q <= 3'd0;
            attr_q  <= COL;
        end else if (advance) begin
            for (int n = 0; n < ROW_PIX - 1; n++) begin
                shreg_q[n] <= shreg_q[n+1];
            end
            shreg_q[ROW_PIX-1] <= '0;
            count_q <= count_q + 3'd1;
        end
    end

    k051962_fine_delay u_fine_delay (
        .clk_24M (clk_24M),
        .nRES    (nRES),
        .PIX_CE  (PIX_CE),
        .FINE    (FINE),
        .din     (stream),
        .dout    (tap)
    );

    assign PIX    = tap.pix;
    assign PCOL   = tap.col;
    assign OPAQUE = |tap.pix;

endmodule
